// File: rtl/rot_serial_loader_pkg.sv
// Shared types and sizes for the serial loader in front of the 16-bit barrel rotator.
package rot_pkg;

    localparam int unsigned W          = 16;  // data word width (only 16 supported)
    localparam int unsigned NW         = 4;   // rotation-amount width, log2(W)
    localparam int unsigned FRAME_BITS = 20;  // NW amount bits + W data bits
    localparam int unsigned N_LAST     = 3;   // counter value on the last amount bit
    localparam int unsigned A_LAST     = 15;  // counter value on the last data bit
    localparam int unsigned CNT_W      = 5;   // bit counter width

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_N = 3'd1,
        LOAD_A = 3'd2,
        ROTATE = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/rot_serial_loader_sipo_shift.sv
// Serial-in / parallel-out shift register, MSB first, with shift enable.
//   clk, rst : clock and asynchronous active-high reset (clears q)
//   en       : shift din into the LSB this edge
//   din      : serial input bit
//   q        : parallel contents
module sipo_shift #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    // Earlier bits migrate toward the MSB as new bits arrive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= {q[WIDTH-2:0], din};
        end
    end

endmodule

// File: rtl/rot_serial_loader.sv
// Serial front/back end for the external 16-bit barrel rotator.
// Loads a 4-bit amount then a 16-bit word (both MSB first) from a serial
// stream, holds them on rot_amt/rot_data, captures rot_result, and offers
// it on a valid/ready output.
//   clk, rst       : clock, asynchronous active-high reset
//   start          : begin a frame (only seen in IDLE)
//   ser_valid/bit  : serial input bit and its qualifier
//   busy           : high whenever not IDLE
//   rot_data/amt   : registered operands to the rotator
//   rot_result     : rotator output, captured in ROTATE
//   out_valid/ready/data : downstream handshake
module rot_serial_loader
    import rot_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          ser_valid,
    input  logic          ser_bit,
    output logic          busy,
    output logic [W-1:0]  rot_data,
    output logic [NW-1:0] rot_amt,
    input  logic [W-1:0]  rot_result,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data
);

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               amt_en;
    logic               data_en;
    logic               capture;
    logic               release_out;

    // State and bit counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state, counter and datapath strobes.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        amt_en      = 1'b0;
        data_en     = 1'b0;
        capture     = 1'b0;
        release_out = 1'b0;
        case (state)
            IDLE: begin
                // A coincident ser_valid bit is dropped on purpose.
                if (start) begin
                    state_next = LOAD_N;
                    cnt_next   = '0;
                end
            end
            LOAD_N: begin
                if (ser_valid) begin
                    amt_en = 1'b1;
                    if (cnt == CNT_W'(N_LAST)) begin
                        state_next = LOAD_A;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
            end
            LOAD_A: begin
                if (ser_valid) begin
                    data_en = 1'b1;
                    if (cnt == CNT_W'(A_LAST)) begin
                        state_next = ROTATE;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
            end
            ROTATE: begin
                capture    = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    release_out = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign busy = (state != IDLE);

    // Amount and data shift registers feeding the rotator.
    sipo_shift #(.WIDTH(NW)) u_amt (
        .clk (clk),
        .rst (rst),
        .en  (amt_en),
        .din (ser_bit),
        .q   (rot_amt)
    );

    sipo_shift #(.WIDTH(W)) u_data (
        .clk (clk),
        .rst (rst),
        .en  (data_en),
        .din (ser_bit),
        .q   (rot_data)
    );

    // Result capture and output handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (capture) begin
            out_valid <= 1'b1;
            out_data  <= rot_result;
        end else if (release_out) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rot_serial_loader.sv
// Directed self-checking bench for rot_serial_loader, with a behavioural
// rotate-right model standing in for the external rotator.
module tb_rot_serial_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        ser_valid;
    logic        ser_bit;
    logic        busy;
    logic [15:0] rot_data;
    logic [3:0]  rot_amt;
    logic [15:0] rot_result;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;

    int n_tests = 0;
    int n_fail  = 0;

    rot_serial_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ser_valid  (ser_valid),
        .ser_bit    (ser_bit),
        .busy       (busy),
        .rot_data   (rot_data),
        .rot_amt    (rot_amt),
        .rot_result (rot_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
    );

    always #5 clk = ~clk;

    // Rotator stand-in: out[i] = data[(i + amt) mod 16].
    logic [31:0] dbl;
    always_comb begin
        dbl        = {rot_data, rot_data} >> rot_amt;
        rot_result = dbl[15:0];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one frame up to out_valid; leaves out_ready to the caller.
    task automatic do_frame(input string tag, input logic [3:0] amt, input logic [15:0] data,
                            input bit gap, input bit start_in_loadn,
                            input logic [15:0] exp_out, input int exp_lat);
        logic [19:0] frame;
        int lat;
        frame = {amt, data};
        // start with a coincident ser_valid bit that must be discarded
        start     = 1'b1;
        ser_valid = 1'b1;
        ser_bit   = 1'b1;
        tick();
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            start     = (start_in_loadn && i < 2) ? 1'b1 : 1'b0;
            ser_valid = 1'b1;
            ser_bit   = frame[19-i];
            tick();
            lat++;
            if (gap && i < 19) begin
                ser_valid = 1'b0;
                ser_bit   = 1'b1;
                tick();
                lat++;
            end
        end
        start     = 1'b0;
        ser_valid = 1'b0;
        ser_bit   = 1'b0;
        check({tag, " rotate rot_amt"}, 32'(rot_amt), 32'(amt));
        check({tag, " rotate rot_data"}, 32'(rot_data), 32'(data));
        check({tag, " rotate out_valid"}, 32'(out_valid), 32'd0);
        while (!out_valid && lat < 60) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " out_data"}, 32'(out_data), 32'(exp_out));
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        ser_valid = 1'b0;
        ser_bit   = 1'b0;
        out_ready = 1'b1;
        #12;
        check("reset busy", 32'(busy), 32'd0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_data", 32'(out_data), 32'd0);
        check("reset rot_data", 32'(rot_data), 32'd0);
        check("reset rot_amt", 32'(rot_amt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Mid-LOAD_A reset: 4 amount bits + 10 data bits, then abort.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 14; i++) begin
            ser_valid = 1'b1;
            ser_bit   = 1'b1;
            tick();
        end
        ser_valid = 1'b0;
        check("pre-abort busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort rot_data", 32'(rot_data), 32'd0);
        check("abort rot_amt", 32'(rot_amt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("post-abort idle", 32'(busy), 32'd0);

        // Full frame after abort; 21 edges after start (22 counting start edge).
        out_ready = 1'b1;
        do_frame("f4_1234", 4'd4, 16'h1234, 1'b0, 1'b0, 16'h4123, 21);
        tick();
        check("f4_1234 idle", 32'(busy), 32'd0);
        check("f4_1234 valid drop", 32'(out_valid), 32'd0);
        check("f4_1234 data hold", 32'(out_data), 32'h4123);

        // Gapped ser_valid, 40 edges after start (41 counting start edge).
        do_frame("f1_8001", 4'd1, 16'h8001, 1'b1, 1'b0, 16'hC000, 40);
        tick();
        check("f1_8001 idle", 32'(busy), 32'd0);

        // Back-to-back frames.
        do_frame("f0_beef", 4'd0, 16'hBEEF, 1'b0, 1'b0, 16'hBEEF, 21);
        tick();
        do_frame("f15_0001", 4'd15, 16'h0001, 1'b0, 1'b0, 16'h0002, 21);
        tick();
        check("f15_0001 idle", 32'(busy), 32'd0);

        // Backpressure with start pulsed during DONE.
        out_ready = 1'b0;
        do_frame("bp", 4'd8, 16'h00FF, 1'b0, 1'b0, 16'hFF00, 21);
        for (int i = 0; i < 5; i++) begin
            start = (i % 2 == 0) ? 1'b1 : 1'b0;
            tick();
            check("bp hold valid", 32'(out_valid), 32'd1);
            check("bp hold data", 32'(out_data), 32'hFF00);
            check("bp hold busy", 32'(busy), 32'd1);
        end
        start     = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp xfer valid", 32'(out_valid), 32'd0);
        check("bp xfer idle", 32'(busy), 32'd0);
        tick();
        check("bp no restart", 32'(busy), 32'd0);

        // start during LOAD_N is ignored.
        do_frame("ldn_start", 4'd12, 16'hA5C3, 1'b0, 1'b1, 16'h5C3A, 21);
        tick();
        check("ldn_start idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
